// File: rtl/halt_pkg.sv
// ----------------------------------------------------------------------------
// halt_pkg: shared state/cause encodings for the halt controller. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

// RISC-V SYSTEM major opcode (inst[6:2]); guarded so a core-wide defines file can take precedence.
`ifndef OPCODE_SYSTEM
`define OPCODE_SYSTEM 5'b11100
`endif

package halt_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_EBREAK = 2'd1,
    CAUSE_EXT    = 2'd2,
    CAUSE_STEP   = 2'd3
  } cause_e;

endpackage

`default_nettype wire

// File: rtl/halt_drain_counter.sv
// ----------------------------------------------------------------------------
// halt_drain_counter: loadable down-counter with zero flag. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module halt_drain_counter #(
  parameter int DRAIN_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [DRAIN_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [DRAIN_W-1:0] cnt_q;
  logic [DRAIN_W-1:0] cnt_d;

  // Load has priority; decrement stops at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DRAIN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/halt_ctrl_unit.sv
// ----------------------------------------------------------------------------
// halt_ctrl_unit: EBREAK/debug halt controller with drain, resume and single-step. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module halt_ctrl_unit
  import halt_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int DRAIN_W      = 3,
  parameter int CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       opcode_i,
  input  logic             ebreak_bit_i,
  input  logic             ext_halt_req_i,
  input  logic             step_mode_i,
  input  logic             resume_req_i,
  output logic             stall_fetch_o,
  output logic             halted_o,
  output logic             resume_ack_o,
  output logic [1:0]       halt_cause_o,
  output logic [CNT_W-1:0] halt_count_o
);

  generate
    if ((DRAIN_CYCLES == 0) || (DRAIN_CYCLES >= (2 ** DRAIN_W))) begin : g_param_check
      $error("halt_ctrl_unit: DRAIN_CYCLES must be in 1..2**DRAIN_W-1");
    end
  endgenerate

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  logic [1:0]       state_q,  state_d;
  logic             stall_q,  stall_d;
  logic             halted_q, halted_d;
  logic             ack_q,    ack_d;
  cause_e           cause_q,  cause_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic trig_ebreak;
  logic drain_load;
  logic drain_dec;
  logic drain_zero;

  assign trig_ebreak = id_valid_i && (opcode_i == `OPCODE_SYSTEM) && ebreak_bit_i;

  halt_drain_counter #(
    .DRAIN_W (DRAIN_W)
  ) u_drain (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (drain_load),
    .load_val_i (DRAIN_LOAD),
    .dec_i      (drain_dec),
    .zero_o     (drain_zero)
  );

  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    halted_d   = halted_q;
    ack_d      = 1'b0;
    cause_d    = cause_q;
    count_d    = count_q;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (trig_ebreak || ext_halt_req_i) begin
          state_d    = ST_DRAIN;
          stall_d    = 1'b1;
          cause_d    = trig_ebreak ? CAUSE_EBREAK : CAUSE_EXT;
          drain_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_zero) begin
          state_d  = ST_HALTED;
          halted_d = 1'b1;
          if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          drain_dec = 1'b1;
        end
      end
      ST_HALTED: begin
        if (resume_req_i) begin
          ack_d    = 1'b1;
          halted_d = 1'b0;
          stall_d  = 1'b0;
          if (step_mode_i) begin
            state_d = ST_STEP;
          end else begin
            state_d = ST_RUN;
            cause_d = CAUSE_NONE;
          end
        end
      end
      ST_STEP: begin
        // The one stepped instruction enters during this cycle; re-freeze behind it.
        state_d    = ST_DRAIN;
        stall_d    = 1'b1;
        cause_d    = CAUSE_STEP;
        drain_load = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      stall_q  <= 1'b0;
      halted_q <= 1'b0;
      ack_q    <= 1'b0;
      cause_q  <= CAUSE_NONE;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      halted_q <= halted_d;
      ack_q    <= ack_d;
      cause_q  <= cause_d;
      count_q  <= count_d;
    end
  end

  assign stall_fetch_o = stall_q;
  assign halted_o      = halted_q;
  assign resume_ack_o  = ack_q;
  assign halt_cause_o  = cause_q;
  assign halt_count_o  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_halt_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_halt_ctrl_unit: scoreboard bench for halt_ctrl_unit (DRAIN_CYCLES=4, CNT_W=2). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_halt_ctrl_unit;

  localparam int DC = 4;
  localparam int CW = 2;

  localparam int K_STALL = 0;
  localparam int K_HALT  = 1;
  localparam int K_ACK   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [4:0]    opcode = 5'd0;
  logic          ebreak_bit = 1'b0;
  logic          ext_req = 1'b0;
  logic          step_mode = 1'b0;
  logic          resume_req = 1'b0;
  logic          stall_fetch;
  logic          halted;
  logic          resume_ack;
  logic [1:0]    halt_cause;
  logic [CW-1:0] halt_count;

  halt_ctrl_unit #(
    .DRAIN_CYCLES (DC),
    .DRAIN_W      (3),
    .CNT_W        (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .id_valid_i     (id_valid),
    .opcode_i       (opcode),
    .ebreak_bit_i   (ebreak_bit),
    .ext_halt_req_i (ext_req),
    .step_mode_i    (step_mode),
    .resume_req_i   (resume_req),
    .stall_fetch_o  (stall_fetch),
    .halted_o       (halted),
    .resume_ack_o   (resume_ack),
    .halt_cause_o   (halt_cause),
    .halt_count_o   (halt_count)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int kind;
    int edge_at;
    int cause;
    int count;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push(input int kind, input int edge_at, input int cause, input int count);
    exp_t e;
    e.kind    = kind;
    e.edge_at = edge_at;
    e.cause   = cause;
    e.count   = count;
    q.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at edge %0d, none expected", kind, edge_n);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_edge", edge_n, e.edge_at);
      if (kind == K_HALT) begin
        chk("halt_cause", int'(halt_cause), e.cause);
        chk("halt_count", int'(halt_count), e.count);
      end else if (kind == K_ACK) begin
        chk("ack_cause", int'(halt_cause), e.cause);
        chk("ack_halted", int'(halted), 0);
        chk("ack_stall", int'(stall_fetch), 0);
      end
    end
  endtask

  // Monitor: turns output transitions into events and matches them against the queue.
  logic p_stall = 1'b0;
  logic p_halted = 1'b0;
  always @(negedge clk) begin
    if (stall_fetch && !p_stall) observe(K_STALL);
    if (halted && !p_halted)     observe(K_HALT);
    if (resume_ack)              observe(K_ACK);
    p_stall  = stall_fetch;
    p_halted = halted;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ebreak_halt(input int exp_cause, input int exp_cnt, input bit also_ext);
    int t;
    t = edge_n + 1;
    push(K_STALL, t, 0, 0);
    push(K_HALT, t + DC, exp_cause, exp_cnt);
    id_valid = 1'b1; opcode = 5'b11100; ebreak_bit = 1'b1; ext_req = also_ext;
    tick(1);
    id_valid = 1'b0; opcode = 5'd0; ebreak_bit = 1'b0; ext_req = 1'b0;
  endtask

  task automatic resume_run(input int hold, input int exp_cause);
    push(K_ACK, edge_n + 1, exp_cause, 0);
    resume_req = 1'b1; step_mode = 1'b0;
    tick(hold);
    resume_req = 1'b0;
    tick(2);
  endtask

  initial begin
    int a;
    tick(3);
    chk("reset_stall", int'(stall_fetch), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_ack", int'(resume_ack), 0);
    chk("reset_cause", int'(halt_cause), 0);
    chk("reset_count", int'(halt_count), 0);
    rst_n = 1'b1;
    tick(1);

    // ECALL, bubbled EBREAK and a non-SYSTEM opcode with bit20 set: no events expected
    id_valid = 1'b1; opcode = 5'b11100; ebreak_bit = 1'b0; tick(8);
    id_valid = 1'b0; ebreak_bit = 1'b1; tick(8);
    id_valid = 1'b1; opcode = 5'b00100; tick(4);
    id_valid = 1'b0; opcode = 5'd0; ebreak_bit = 1'b0;

    // EBREAK halt, then resume held 3 cycles -> one ack
    ebreak_halt(1, 1, 1'b0);
    tick(DC + 2);
    resume_run(3, 0);

    // EBREAK + ext together; resume while draining must be ignored
    ebreak_halt(1, 2, 1'b1);
    resume_req = 1'b1; tick(2); resume_req = 1'b0;
    tick(DC + 1);
    resume_run(1, 0);

    // ext-only halt
    push(K_STALL, edge_n + 1, 0, 0);
    push(K_HALT, edge_n + 1 + DC, 2, 3);
    ext_req = 1'b1; tick(1); ext_req = 1'b0;
    tick(DC + 2);

    // single step: ack, stall low one cycle, re-halt with cause STEP, count saturated
    a = edge_n + 1;
    push(K_ACK, a, 2, 0);
    push(K_STALL, a + 1, 0, 0);
    push(K_HALT, a + 1 + DC, 3, 3);
    resume_req = 1'b1; step_mode = 1'b1; tick(1);
    resume_req = 1'b0; step_mode = 1'b0;
    tick(DC + 3);

    // resume with ext still high re-triggers from RUN next cycle
    a = edge_n + 1;
    push(K_ACK, a, 0, 0);
    push(K_STALL, a + 1, 0, 0);
    push(K_HALT, a + 1 + DC, 2, 3);
    ext_req = 1'b1; resume_req = 1'b1; tick(1);
    resume_req = 1'b0; tick(1);
    ext_req = 1'b0;
    tick(DC + 2);
    resume_run(1, 0);

    // reset in the middle of a drain
    push(K_STALL, edge_n + 1, 0, 0);
    id_valid = 1'b1; opcode = 5'b11100; ebreak_bit = 1'b1; tick(1);
    id_valid = 1'b0; opcode = 5'd0; ebreak_bit = 1'b0;
    tick(2);
    rst_n = 1'b0; tick(1);
    chk("midreset_stall", int'(stall_fetch), 0);
    chk("midreset_halted", int'(halted), 0);
    chk("midreset_cause", int'(halt_cause), 0);
    chk("midreset_count", int'(halt_count), 0);
    rst_n = 1'b1; tick(DC + 4);

    // count restarts from zero after reset
    ebreak_halt(1, 1, 1'b0);
    tick(DC + 3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unconsumed, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
